// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the mainP datapath, with a memory timeout watchdog.
// Optional SEQ_PERF_CNT_EN adds retired-instruction and active-cycle counters.
module cpu_seq_ctrl #(
  parameter int              OP_W        = 4,
  parameter int              TO_W        = 8,
  parameter logic [TO_W-1:0] MEM_TIMEOUT = TO_W'(64)
) (
  input  logic            clk,
  input  logic            pcrst,
  input  logic [OP_W-1:0] ir_op,
  input  logic            alu_zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_load,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            alu_en,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            halted,
  output logic            illegal_op,
  output logic            bus_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     instr_cnt,
  output logic [31:0]     cyc_cnt
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ALU_L = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ALU_H = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);
  localparam logic [TO_W-1:0] TO_LAST  = MEM_TIMEOUT - TO_W'(1);

  state_t          state, next_state;
  logic [TO_W-1:0] to_cnt;
  logic            is_nop, is_alu, is_load, is_store, is_beq, is_jmp, is_halt, is_illegal;
  logic            wait_st, to_fire, illegal_set;

  always_comb begin
    is_nop     = (ir_op == OP_NOP);
    is_alu     = (ir_op >= OP_ALU_L) && (ir_op <= OP_ALU_H);
    is_load    = (ir_op == OP_LOAD);
    is_store   = (ir_op == OP_STORE);
    is_beq     = (ir_op == OP_BEQ);
    is_jmp     = (ir_op == OP_JMP);
    is_halt    = (ir_op == OP_HALT);
    is_illegal = !(is_nop || is_alu || is_load || is_store || is_beq || is_jmp || is_halt);
  end

  // Watchdog only arms in the two states that own the memory port.
  assign wait_st = (state == S_FETCH) || (state == S_MEM);
  assign to_fire = (MEM_TIMEOUT != '0) && wait_st && !mem_ack && (to_cnt == TO_LAST);

  always_comb begin
    next_state   = state;
    illegal_set  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_en       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else if (to_fire) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_illegal) begin
          illegal_set = 1'b1;
          next_state  = S_HALT;
        end else begin
          pc_we = 1'b1;
          if (is_nop)       next_state = S_FETCH;
          else if (is_halt) next_state = S_HALT;
          else              next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_alu)                     next_state = S_WB;
        else if (is_load || is_store)   next_state = S_MEM;
        else begin
          if (is_beq && alu_zero) begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end else if (is_jmp) begin
            pc_we  = 1'b1;
            pc_src = 2'd3;
          end
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ack)      next_state = is_load ? S_WB : S_FETCH;
        else if (to_fire) next_state = S_HALT;
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel     = is_load;
        next_state = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: next_state = S_HALT;
    endcase
    // Reset silences the port at once rather than waiting for the next edge.
    if (pcrst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      alu_en       = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge pcrst) begin
    if (pcrst) begin
      state      <= S_FETCH;
      to_cnt     <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (wait_st && !mem_ack && (next_state == state)) to_cnt <= to_cnt + TO_W'(1);
      else                                              to_cnt <= '0;
      if (illegal_set) illegal_op <= 1'b1;
      if (to_fire)     bus_err    <= 1'b1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge pcrst) begin
    if (pcrst) begin
      instr_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (state != S_HALT) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if ((next_state == S_FETCH) && (state != S_FETCH)) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-cycle output vectors checked against hand-built tables.
module tb_cpu_seq_ctrl;
  logic       clk = 1'b0;
  logic       pcrst = 1'b1;
  logic [3:0] ir_op = 4'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_we, alu_en, rf_we, wb_sel;
  logic       halted, illegal_op, bus_err;
  logic [1:0] pc_src;
  int         n_cmp = 0;
  int         n_fail = 0;

  cpu_seq_ctrl #(.OP_W(4), .TO_W(8), .MEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .pcrst(pcrst), .ir_op(ir_op), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_we(pc_we), .pc_src(pc_src), .alu_en(alu_en), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  wire [12:0] outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_we, pc_src,
                      alu_en, rf_we, wb_sel, halted, illegal_op, bus_err};

  localparam logic [12:0] REQ  = 13'h1000, WE   = 13'h0800, ASEL = 13'h0400, IRL = 13'h0200;
  localparam logic [12:0] PCW  = 13'h0100, SRC2 = 13'h0080, SRC3 = 13'h00C0, ALU = 13'h0020;
  localparam logic [12:0] RFW  = 13'h0010, WBS  = 13'h0008, HLT  = 13'h0004, ILL = 13'h0002;
  localparam logic [12:0] BER  = 13'h0001;

  // Leaves the bench one tick after a rising edge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    pcrst = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    pcrst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (outs !== 13'h0) begin n_fail++; $display("FAIL reset_init outs=%h exp=%h", outs, 13'h0); end
    @(posedge clk); #1;
    pcrst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== REQ) begin n_fail++; $display("FAIL reset_fetch outs=%h exp=%h", outs, REQ); end
    #1 pcrst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 13'h0) begin n_fail++; $display("FAIL reset_async outs=%h exp=%h", outs, 13'h0); end
    @(posedge clk); #1;
    pcrst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== REQ) begin n_fail++; $display("FAIL reset_release outs=%h exp=%h", outs, REQ); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [12:0] exp [5] = '{REQ|IRL, PCW, ALU, RFW, REQ|IRL};
    do_reset();
    ir_op = 4'd3; alu_zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp[i]) begin n_fail++; $display("FAIL alu c%0d outs=%h exp=%h", i, outs, exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic        ack [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [12:0] exp [8] = '{REQ|IRL, PCW, ALU, REQ|ASEL, REQ|ASEL, REQ|ASEL, RFW|WBS, REQ};
    do_reset();
    ir_op = 4'd8;
    for (int i = 0; i < 8; i++) begin
      mem_ack = ack[i];
      @(negedge clk);
      n_cmp++;
      if (outs !== exp[i]) begin n_fail++; $display("FAIL load c%0d outs=%h exp=%h", i, outs, exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [12:0] exp [5] = '{REQ|IRL, PCW, ALU, REQ|ASEL|WE, REQ|IRL};
    do_reset();
    ir_op = 4'd9;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp[i]) begin n_fail++; $display("FAIL store c%0d outs=%h exp=%h", i, outs, exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [3:0]  ops [4]    = '{4'hA, 4'hA, 4'hB, 4'h0};
    logic        zs  [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [12:0] exp [4][4] = '{'{REQ|IRL, PCW, ALU|PCW|SRC2, REQ|IRL},
                                '{REQ|IRL, PCW, ALU,          REQ|IRL},
                                '{REQ|IRL, PCW, ALU|PCW|SRC3, REQ|IRL},
                                '{REQ|IRL, PCW, REQ|IRL,      PCW}};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      ir_op = ops[t]; alu_zero = zs[t];
      for (int i = 0; i < 4; i++) begin
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs !== exp[t][i])
          begin n_fail++; $display("FAIL branch t%0d c%0d outs=%h exp=%h", t, i, outs, exp[t][i]); end
        @(posedge clk); #1;
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_halt_illegal();
    logic [3:0]  ops [2]    = '{4'hD, 4'hF};
    logic [12:0] exp [2][4] = '{'{REQ|IRL, 13'h0, HLT|ILL, HLT|ILL},
                                '{REQ|IRL, PCW,   HLT,     HLT}};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      ir_op = ops[t];
      for (int i = 0; i < 4; i++) begin
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs !== exp[t][i])
          begin n_fail++; $display("FAIL halt t%0d c%0d outs=%h exp=%h", t, i, outs, exp[t][i]); end
        @(posedge clk); #1;
      end
    end
    // Sticky flag must clear asynchronously on reset.
    pcrst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 13'h0) begin n_fail++; $display("FAIL halt_reset outs=%h exp=%h", outs, 13'h0); end
  endtask

  task automatic test_timeout();
    logic        ack [3][8] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                                '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
                                '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    logic [3:0]  ops [3]    = '{4'h0, 4'h0, 4'h8};
    logic [12:0] exp [3][8] = '{'{REQ, REQ, REQ, REQ, HLT|BER, HLT|BER, HLT|BER, HLT|BER},
                                '{REQ, REQ, REQ, REQ|IRL, PCW, REQ, REQ, REQ},
                                '{REQ|IRL, PCW, ALU, REQ|ASEL, REQ|ASEL, REQ|ASEL, REQ|ASEL, HLT|BER}};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      ir_op = ops[t];
      for (int i = 0; i < 8; i++) begin
        mem_ack = ack[t][i];
        @(negedge clk);
        n_cmp++;
        if (outs !== exp[t][i])
          begin n_fail++; $display("FAIL timeout t%0d c%0d outs=%h exp=%h", t, i, outs, exp[t][i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [9] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'hB, 4'hB, 4'hB};
    logic [12:0] exp [9] = '{REQ|IRL, PCW, ALU, RFW, REQ|IRL, PCW, REQ|IRL, PCW, ALU|PCW|SRC3};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ir_op = ops[i];
      mem_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp[i]) begin n_fail++; $display("FAIL b2b c%0d outs=%h exp=%h", i, outs, exp[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_halt_illegal();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
